// File: rtl/seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver: double-buffered digit codes,
// leading-zero blanking, per-digit blink and an anode-off guard at each slot start.
module seg_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 128,
  parameter bit          HEX_EN       = 1'b1,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] bNums,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  input  logic                blink_en,
  input  logic [DIGITS-1:0]   blink_mask,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned NUM_W  = 4 * DIGITS;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // Logical abcdefg glyph for one digit code; a is bit 0.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] g;
    g = 7'h00;
    case (code)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = HEX_EN ? 7'h77 : 7'h00;
      4'hB: g = HEX_EN ? 7'h7C : 7'h00;
      4'hC: g = HEX_EN ? 7'h39 : 7'h00;
      4'hD: g = HEX_EN ? 7'h5E : 7'h00;
      4'hE: g = HEX_EN ? 7'h79 : 7'h00;
      4'hF: g = HEX_EN ? 7'h71 : 7'h00;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FRM_W-1:0]  frm_q, frm_d;
  logic              phase_q, phase_d;
  logic              pend_q, pend_d;
  logic              fresh_q;
  logic [NUM_W-1:0]  shadow_num_q, shadow_num_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [NUM_W-1:0]  act_num_q, act_num_d;
  logic [DIGITS-1:0] act_dp_q, act_dp_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              fdone_q, fdone_d;

  logic              slot_last, wrap, refresh, in_guard, dark;
  logic              all_zero, lz_bit, mask_bit, dp_bit, dp_log;
  logic [3:0]        code;
  logic [6:0]        seg_log;
  logic [DIGITS-1:0] an_log;

  always_comb begin
    slot_last = (slot_q == SLOT_LAST);
    wrap      = slot_last && (idx_q == IDX_LAST);
    slot_d    = slot_last ? '0 : slot_q + SLOT_W'(1);
    idx_d     = idx_q;
    if (slot_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // Blink phase advances once per BLINK_FRAMES completed frames.
    frm_d   = frm_q;
    phase_d = phase_q;
    if (wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end

    // Active buffer only changes on frame wrap, so a frame never mixes old and new data.
    shadow_num_d = shadow_num_q;
    shadow_dp_d  = shadow_dp_q;
    act_num_d    = act_num_q;
    act_dp_d     = act_dp_q;
    pend_d       = pend_q;
    if (load) begin
      shadow_num_d = bNums;
      shadow_dp_d  = dp_in;
    end
    if (wrap) begin
      pend_d = 1'b0;
      if (load) begin
        act_num_d = bNums;
        act_dp_d  = dp_in;
      end else if (pend_q) begin
        act_num_d = shadow_num_q;
        act_dp_d  = shadow_dp_q;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end

    // Walk from the top digit down so all_zero covers every digit j >= i.
    code     = 4'h0;
    dp_bit   = 1'b0;
    mask_bit = 1'b0;
    lz_bit   = 1'b0;
    all_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero = all_zero && (act_num_d[4*i +: 4] == 4'h0);
      if (idx_d == IDX_W'(i)) begin
        code     = act_num_d[4*i +: 4];
        dp_bit   = act_dp_d[i];
        mask_bit = blink_mask[i];
        lz_bit   = all_zero && (i != 0);
      end
    end

    dark     = (blank_lz && lz_bit) || (blink_en && !phase_d && mask_bit);
    seg_log  = dark ? 7'h00 : seg_decode(code);
    dp_log   = dp_bit && !dark;
    in_guard = (32'(slot_d) + 32'd1) <= GUARD;
    an_log   = in_guard ? '0 : (DIGITS'(1) << idx_d);

    // Segment data is latched once per slot; the first slot after reset latches on the first edge.
    refresh = fresh_q || (slot_d == '0);
    seg_d   = refresh ? (seg_log ^ {7{ACTIVE_LOW}}) : seg_q;
    dp_d    = refresh ? (dp_log ^ ACTIVE_LOW) : dp_q;
    an_d    = an_log ^ {DIGITS{ACTIVE_LOW}};
    fdone_d = (slot_d == SLOT_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b1;
      pend_q       <= 1'b0;
      fresh_q      <= 1'b1;
      shadow_num_q <= '0;
      shadow_dp_q  <= '0;
      act_num_q    <= '0;
      act_dp_q     <= '0;
      seg_q        <= {7{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
      an_q         <= {DIGITS{ACTIVE_LOW}};
      fdone_q      <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      fresh_q      <= 1'b0;
      shadow_num_q <= shadow_num_d;
      shadow_dp_q  <= shadow_dp_d;
      act_num_q    <= act_num_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fdone_q      <= fdone_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (active-high/hex/guard=1 and
// active-low/no-hex/guard=0) compared each cycle against a time-based display model.
module tb_seg_scan_driver;

  localparam int D     = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = D * SD;
  localparam int G_A   = 1;
  localparam int G_B   = 0;
  localparam int MAXE  = 8192;

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } obs_t;

  typedef struct {
    int          ev;
    logic [15:0] num;
    logic [3:0]  dp;
  } load_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bNums = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fd_a, fd_b;
  logic [3:0]  an_a, an_b;

  int          checks = 0;
  int          errors = 0;
  logic [25:0] got, exp;

  int          ecount = 0;
  logic        h_lz   [MAXE];
  logic        h_ben  [MAXE];
  logic [3:0]  h_mask [MAXE];
  load_t       ld_q[$];

  seg_scan_driver #(
    .DIGITS(D), .SCAN_DIV(SD), .GUARD(G_A), .BLINK_FRAMES(BF), .HEX_EN(1'b1), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .load(load), .bNums(bNums), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
    .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a)
  );

  seg_scan_driver #(
    .DIGITS(D), .SCAN_DIV(SD), .GUARD(G_B), .BLINK_FRAMES(BF), .HEX_EN(1'b0), .ACTIVE_LOW(1'b1)
  ) u_alt (
    .clk(clk), .rst(rst), .load(load), .bNums(bNums), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
    .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  // Edge log since reset release: controls seen at each edge and every load with its edge number.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecount = 0;
      ld_q.delete();
    end else begin
      ecount = ecount + 1;
      if (ecount < MAXE) begin
        h_lz[ecount]   = blank_lz;
        h_ben[ecount]  = blink_en;
        h_mask[ecount] = blink_mask;
      end
      if (load) ld_q.push_back('{ecount, bNums, dp_in});
    end
  end

  // Expected pins after e edges: frame f shows the last load taken at or before the edge
  // that started it; controls come from the edge that started the current slot.
  function automatic obs_t model(input int e, input bit alt);
    obs_t        o;
    int          slot, idx, f, se;
    logic [15:0] num;
    logic [3:0]  dpv, code;
    bit          dark;
    o = '0;
    if (e > 0) begin
      slot = e % SD;
      idx  = (e / SD) % D;
      f    = e / FRAME;
      se   = (e == slot) ? 1 : e - slot;
      if (se >= MAXE) se = MAXE - 1;
      num = '0;
      dpv = '0;
      foreach (ld_q[k]) begin
        if (ld_q[k].ev <= f * FRAME) begin
          num = ld_q[k].num;
          dpv = ld_q[k].dp;
        end
      end
      code  = num[4*idx +: 4];
      dark  = (h_lz[se] && idx != 0 && (num >> (4 * idx)) == 16'h0) ||
              (h_ben[se] && ((f / BF) % 2 == 1) && h_mask[se][idx]);
      o.seg = (dark || (alt && code > 4'd9)) ? 7'h00 : GLYPH[code];
      o.dp  = dpv[idx] && !dark;
      o.an  = (slot < (alt ? G_B : G_A)) ? 4'h0 : 4'(1 << idx);
      o.fd  = (slot == SD - 1) && (idx == D - 1);
    end
    if (alt) begin
      o.seg = ~o.seg;
      o.dp  = ~o.dp;
      o.an  = ~o.an;
    end
    return o;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
    exp = {model(0, 1'b0), model(0, 1'b1)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", got, exp);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
      exp = {model(ecount, 1'b0), model(ecount, 1'b1)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_first_frame e=%0d got=%h exp=%h", ecount, got, exp);
      end
    end
  endtask

  task automatic test_scan_basic();
    load = 1'b1; bNums = 16'h1234; dp_in = 4'b0100;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
      exp = {model(ecount, 1'b0), model(ecount, 1'b1)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL scan_basic e=%0d got=%h exp=%h", ecount, got, exp);
      end
      load = 1'b0;
    end
  endtask

  task automatic test_lz();
    blank_lz = 1'b1;
    for (int c = 0; c < 5 * FRAME; c++) begin
      @(negedge clk);
      got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
      exp = {model(ecount, 1'b0), model(ecount, 1'b1)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL leading_zero e=%0d got=%h exp=%h", ecount, got, exp);
      end
      load = 1'b0;
      if (c == 0) begin
        load = 1'b1; bNums = 16'h0007; dp_in = 4'b1111;
      end else if (c == 2 * FRAME + 3) begin
        load = 1'b1; bNums = 16'h0000; dp_in = 4'b0000;
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_midframe();
    bit sent = 1'b0;
    for (int c = 0; c < 5 * FRAME; c++) begin
      @(negedge clk);
      got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
      exp = {model(ecount, 1'b0), model(ecount, 1'b1)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midframe_load e=%0d got=%h exp=%h", ecount, got, exp);
      end
      load = 1'b0;
      if (c == 0) begin
        load = 1'b1; bNums = 16'h1234; dp_in = 4'b0000;
      end else if (!sent && c > 2 * FRAME && (ecount % FRAME) == 6) begin
        load = 1'b1; bNums = 16'hAAAA; dp_in = 4'b0000; sent = 1'b1;
      end
    end
  endtask

  task automatic test_wrap_load();
    bit sent = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
      exp = {model(ecount, 1'b0), model(ecount, 1'b1)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wrap_load e=%0d got=%h exp=%h", ecount, got, exp);
      end
      load = 1'b0;
      if (!sent && (ecount % FRAME) == FRAME - 1) begin
        load = 1'b1; bNums = 16'h5678; dp_in = 4'b0001; sent = 1'b1;
      end
    end
  endtask

  task automatic test_blink();
    blink_en = 1'b1; blink_mask = 4'b0010;
    load = 1'b1; bNums = 16'h8888; dp_in = 4'b1111;
    for (int c = 0; c < 10 * FRAME; c++) begin
      @(negedge clk);
      got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
      exp = {model(ecount, 1'b0), model(ecount, 1'b1)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL blink e=%0d got=%h exp=%h", ecount, got, exp);
      end
      load = 1'b0;
      if (c == 8 * FRAME) blink_en = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 40 * FRAME; c++) begin
      @(negedge clk);
      got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
      exp = {model(ecount, 1'b0), model(ecount, 1'b1)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random e=%0d got=%h exp=%h", ecount, got, exp);
      end
      load = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        load  = 1'b1;
        bNums = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 24) == 0) blink_mask = 4'($urandom);
    end
    load = 1'b0; blank_lz = 1'b0; blink_en = 1'b0; blink_mask = '0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < FRAME && (ecount % FRAME) != 5; c++) @(negedge clk);
    load = 1'b1; bNums = 16'h9999; dp_in = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
    exp = {model(0, 1'b0), model(0, 1'b1)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_mid_slot got=%h exp=%h", got, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      got = {seg_a, dp_a, an_a, fd_a, seg_b, dp_b, an_b, fd_b};
      exp = {model(ecount, 1'b0), model(ecount, 1'b1)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL after_reset e=%0d got=%h exp=%h", ecount, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_lz();
    test_midframe();
    test_wrap_load();
    test_blink();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed multi-digit 7-segment display driver. It takes a packed vector of 4-bit digit codes and scans them onto one shared segment bus with per-digit anode enables. Beyond a single-digit decoder, it adds digit scanning, tear-free double-buffered update, leading-zero blanking, per-digit blink and anti-ghosting guard time. It sits between the timer/alarm datapath and the board's display pins.

## Interface

- DIGITS, 4: number of digits scanned (1..8).
- SCAN_DIV, 1000: clocks per digit slot (>= GUARD+1).
- GUARD, 2: clocks at the start of each slot during which all anodes are off (0 = none).
- BLINK_FRAMES, 128: full scan frames per blink half-period (>= 1).
- HEX_EN, 1: 1 = codes 10..15 render A,b,C,d,E,F; 0 = codes 10..15 render blank.
- ACTIVE_LOW, 0: 1 inverts seg, dp and an at the pins.
- clk  in  1  system clock, single domain.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  one-cycle strobe that captures bNums/dp_in into the shadow buffer.
- bNums  in  4*DIGITS  digit codes; digit i = bNums[4i+3:4i]; digit 0 is least significant (rightmost).
- dp_in  in  DIGITS  decimal point per digit.
- blank_lz  in  1  leading-zero blanking enable (level, sampled live).
- blink_en  in  1  global blink enable (level).
- blink_mask  in  DIGITS  digits subject to blink.
- seg  out  7  segments; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point of the current digit.
- an  out  DIGITS  one-hot digit enable.
- frame_done  out  1  one-cycle pulse when the last digit slot completes.

## Operation

- Encoding, logical (active-high) abcdefg with a at bit 0: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Blank = 00.
- Buffers: shadow (bNums, dp_in) plus pending flag; active buffer drives the display.
  - load captures into shadow and sets pending.
  - At frame wrap, when digit index goes DIGITS-1 -> 0 and pending=1, shadow is copied to active and pending is cleared.
  - load in the same cycle as a wrap writes directly to active and leaves pending=0.
  - Repeated loads before a wrap overwrite the shadow; only the last one is shown.
- Scan:
  - slot_cnt counts 0..SCAN_DIV-1.
  - At terminal count, digit_idx increments, wrapping DIGITS-1 -> 0.
  - Digits are scanned 0,1,…,DIGITS-1.
- Leading-zero blanking: when blank_lz=1, digit i is blanked if every active digit j >= i equals 0. Digit 0 is never blanked. A blanked digit also forces dp=0.
- Blink:
  - frame_cnt counts completed frames, 0..BLINK_FRAMES-1.
  - At its terminal count, blink_phase toggles.
  - When blink_en=1, blink_phase=off and blink_mask[i]=1, digit i shows seg=0 and dp=0.
  - When blink_en=0, blink_phase still runs and no digit blinks.
- Guard: while slot_cnt < GUARD, an = all off. seg and dp already carry the new digit.
- ACTIVE_LOW applies only at the output registers.

## Timing

- All outputs are registered and update on the same edge that advances slot_cnt or digit_idx.
- Digit slot length is exactly SCAN_DIV clocks. The an one-hot for digit k is asserted for SCAN_DIV-GUARD clocks.
- A frame is DIGITS*SCAN_DIV clocks.
- frame_done is high for the single cycle in which slot_cnt=SCAN_DIV-1 and digit_idx=DIGITS-1.
- Load-to-display latency is at most one frame plus one clock. No partial frame ever mixes old and new data.
- blank_lz, blink_en and blink_mask act on the next slot boundary. They are sampled when seg is computed for the slot.
- Reset values, asserted asynchronously (logical values, before polarity):
  - slot_cnt=0, digit_idx=0, frame_cnt=0.
  - blink_phase=on, pending=0, shadow and active buffers all 0.
  - an=0, seg=00, dp=0, frame_done=0.
- Reset mid-frame aborts the scan immediately, outputs go to their reset values, and any pending load is discarded.
- After reset release, the first slot is digit 0 with a full guard interval.

## Test plan

- Reset, then load bNums=0x1234, DIGITS=4, SCAN_DIV=4, GUARD=1 -> after the next wrap, the slots show seg=66,4F,5B,06 (digits 0..3), with an=0 for 1 clk then 0001,0010,0100,1000 for 3 clk each; frame_done pulses every 16 clk.
- Load 0x0007 with blank_lz=1 -> digits 3..1 show seg=00 with dp=0, digit 0 shows 07. Load 0x0000 -> only digit 0 shows 3F.
- Mid-frame load 0xAAAA while displaying 0x1234 -> the current frame finishes unchanged. The next frame shows 77 on all digits, or 00 on all digits with HEX_EN=0.
- Load coincident with frame wrap -> the new value appears in digit 0 of the immediately starting frame, and pending stays 0.
- blink_en=1, blink_mask=0010, BLINK_FRAMES=2 -> digit 1 is dark for frames 2-3, 6-7, and so on. The other digits are unaffected. With ACTIVE_LOW=1, all pins are inverted.
- Assert rst mid-slot -> an, seg and dp go to all-off in the same cycle with no clock edge. After release, digit 0 shows 3F following the guard interval, and a load issued before the reset is not displayed.
